mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on posedge Clk.
REQ-002 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have inputs from the EX/MEM register: RegWrite, MemRead, MemWrite, loadhalf, loadbyte, storehalf, storebyte (1 each); MemtoReg (2); ALUResult (32, address/ALU value); WriteData (32); RTorRd (5).
REQ-004 SHALL have a memory port: mem_req out 1; mem_we out 1; mem_addr out 30 (word address = ALUResult[31:2]); mem_be out 4; mem_wdata out 32; mem_rdata in 32; mem_ack in 1.
REQ-005 SHALL have MEM/WB outputs, all registered: RegWrite_wb 1; MemtoReg_wb 2; ReadData_wb 32; ALUResult_wb 32; RTorRd_wb 5.
REQ-006 SHALL have outputs Stall (1, combinational: hold PC/IF/ID/EX/MEM), AlignErr (1, registered, one-cycle pulse) and BusErr (1, registered, one-cycle pulse).

Function
REQ-007 SHALL define op = MemRead|MemWrite; MemWrite has priority when both are 1 (store performed, no load).
REQ-008 SHALL define misaligned = (half op & ALUResult[0]) | (word op & ALUResult[1:0]!=0); byte ops are never misaligned.
REQ-009 SHALL implement FSM states IDLE and WAIT, plus an 8-bit wait counter.
REQ-010 IDLE: op & aligned -> drive mem_req=1 in the same cycle; on mem_ack that cycle, complete; otherwise go to WAIT, counter=1.
REQ-011 WAIT: mem_req=1, address/be/wdata/we held stable from EX/MEM inputs; on mem_ack -> complete, go IDLE; counter==255 without ack -> BusErr pulse, bubble to MEM/WB, go IDLE.
REQ-012 SHALL assert Stall = op & aligned & ~mem_ack & ~timeout, where timeout denotes the counter==255 cycle.
REQ-013 Completion or non-op cycle SHALL capture RegWrite, MemtoReg, ALUResult, RTorRd into the *_wb registers on that edge (latency 1 after ack/present).
REQ-014 While Stall=1, the MEM/WB outputs SHALL take a bubble (RegWrite_wb=0, MemtoReg_wb=0, RTorRd_wb=0; other fields don't-care, driven 0).
REQ-015 Misaligned op SHALL issue no mem_req, SHALL NOT stall, SHALL pulse AlignErr, and SHALL write a bubble to MEM/WB.
REQ-016 Store lanes are little-endian: sb -> mem_wdata={4{WriteData[7:0]}}, mem_be=4'b0001<<ALUResult[1:0]; sh -> {2{WriteData[15:0]}}, be=ALUResult[1]?1100:0011; sw -> WriteData, be=1111; mem_we=1.
REQ-017 Loads: mem_we=0, mem_be=1111; lb sign-extends byte lane ALUResult[1:0]; lh sign-extends half lane ALUResult[1]; lw uses mem_rdata unchanged; result captured into ReadData_wb on the ack edge.
REQ-018 Non-load completion SHALL set ReadData_wb=0.
REQ-019 mem_ack while mem_req=0 SHALL be ignored.
REQ-020 mem_req, mem_we, mem_be, mem_wdata SHALL be 0 when no request is driven.

Reset
REQ-021 Reset=1 at an edge SHALL set state=IDLE, counter=0, all *_wb outputs 0, AlignErr=0, BusErr=0, overriding all other events in that cycle.
REQ-022 Reset in WAIT SHALL abandon the access; mem_req=0 from the following cycle; a late mem_ack is ignored (REQ-019).
REQ-023 While Reset=1, Stall and mem_req SHALL be forced 0.

Verification
REQ-024 lw, ALUResult=0x100, mem_ack on 3rd req cycle, mem_rdata=0xDEADBEEF -> Stall high 2 cycles, mem_addr=0x40, ReadData_wb=0xDEADBEEF next edge, RegWrite_wb bubbled for 2 cycles.
REQ-025 lb at 0x103, mem_rdata=0x80FF1234 with immediate ack -> no Stall, ReadData_wb=0xFFFFFF80; lh at 0x102 -> 0xFFFF80FF.
REQ-026 sh at 0x106, WriteData=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; sb at 0x101, WriteData=0x5A -> be=0010.
REQ-027 lw at 0x102 -> no mem_req, AlignErr pulse 1 cycle, Stall=0, RegWrite_wb=0.
REQ-028 sw with mem_ack never asserted -> Stall high 255 cycles, BusErr pulse, return IDLE; repeat with Reset asserted in 5th WAIT cycle -> mem_req=0 next cycle, all *_wb=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose : MEM pipeline stage; issues load/store requests on a simple req/ack memory port and
//           registers the MEM/WB stage outputs.
// Latency : MEM/WB registers update on the edge where mem_ack is seen, or where no memory op is present.
// Backpr. : Stall is held combinationally while a request waits for ack. After 255 unacked cycles the
//           stage gives up and pulses BusErr.
// Ports   : Clk/Reset (sync, active-high); EX/MEM control + ALUResult/WriteData/RTorRd in;
//           mem_* request port; *_wb MEM/WB registers out; Stall, AlignErr, BusErr.
module mem_access_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        loadhalf,
    input  logic        loadbyte,
    input  logic        storehalf,
    input  logic        storebyte,
    input  logic [1:0]  MemtoReg,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [4:0]  RTorRd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        RegWrite_wb,
    output logic [1:0]  MemtoReg_wb,
    output logic [31:0] ReadData_wb,
    output logic [31:0] ALUResult_wb,
    output logic [4:0]  RTorRd_wb,
    output logic        Stall,
    output logic        AlignErr,
    output logic        BusErr
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        regwrite_q, regwrite_d;
    logic [1:0]  memtoreg_q, memtoreg_d;
    logic [31:0] readdata_q, readdata_d;
    logic [31:0] aluresult_q, aluresult_d;
    logic [4:0]  rtord_q, rtord_d;
    logic        alignerr_q, alignerr_d;
    logic        buserr_q, buserr_d;

    // Access decode. A store wins over a load when both strobes are set, so
    // the size bits are taken from the store set in that case.
    logic op, is_load, is_byte, is_half, is_word, misaligned, aligned_op;
    logic timeout, complete, capture;

    assign op         = MemRead | MemWrite;
    assign is_load    = MemRead & ~MemWrite;
    assign is_byte    = MemWrite ? storebyte : loadbyte;
    assign is_half    = ~is_byte & (MemWrite ? storehalf : loadhalf);
    assign is_word    = ~is_byte & ~is_half;
    assign misaligned = (is_half & ALUResult[0]) | (is_word & (ALUResult[1:0] != 2'b00));
    assign aligned_op = op & ~misaligned;
    assign timeout    = (state_q == WAIT) && (cnt_q == 8'hFF);
    // Under reset the registers are cleared regardless, so these need no reset term.
    assign complete   = aligned_op & mem_ack;
    assign capture    = complete | ~op;

    assign mem_addr   = ALUResult[31:2];

    // Load lane extraction, little-endian.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    always_comb begin
        case (ALUResult[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ALUResult[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (is_byte)
            load_val = {{24{ld_byte[7]}}, ld_byte};
        else if (is_half)
            load_val = {{16{ld_half[15]}}, ld_half};
        else
            load_val = mem_rdata;
    end

    // State register, including the MEM/WB pipeline registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 2'd0;
            readdata_q  <= 32'd0;
            aluresult_q <= 32'd0;
            rtord_q     <= 5'd0;
            alignerr_q  <= 1'b0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            readdata_q  <= readdata_d;
            aluresult_q <= aluresult_d;
            rtord_q     <= rtord_d;
            alignerr_q  <= alignerr_d;
            buserr_q    <= buserr_d;
        end
    end

    // Next state. The counter holds the number of cycles already spent in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!aligned_op || mem_ack || timeout) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == IDLE) begin
            state_d = WAIT;
            cnt_d   = 8'd1;
        end else begin
            cnt_d   = cnt_q + 8'd1;
        end
    end

    // Outputs. Memory port and Stall are combinational from the EX/MEM inputs.
    // The MEM/WB next values carry a bubble unless this cycle completes.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        Stall     = 1'b0;
        if (!Reset && aligned_op) begin
            mem_req = 1'b1;
            mem_we  = MemWrite;
            Stall   = ~mem_ack & ~timeout;
            if (MemWrite) begin
                if (is_byte) begin
                    mem_be    = 4'b0001 << ALUResult[1:0];
                    mem_wdata = {4{WriteData[7:0]}};
                end else if (is_half) begin
                    mem_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{WriteData[15:0]}};
                end else begin
                    mem_be    = 4'b1111;
                    mem_wdata = WriteData;
                end
            end else begin
                mem_be = 4'b1111;
            end
        end

        regwrite_d  = 1'b0;
        memtoreg_d  = 2'd0;
        readdata_d  = 32'd0;
        aluresult_d = 32'd0;
        rtord_d     = 5'd0;
        if (capture) begin
            regwrite_d  = RegWrite;
            memtoreg_d  = MemtoReg;
            aluresult_d = ALUResult;
            rtord_d     = RTorRd;
            readdata_d  = (is_load & complete) ? load_val : 32'd0;
        end
        alignerr_d = op & misaligned;
        buserr_d   = aligned_op & ~mem_ack & timeout;
    end

    assign RegWrite_wb  = regwrite_q;
    assign MemtoReg_wb  = memtoreg_q;
    assign ReadData_wb  = readdata_q;
    assign ALUResult_wb = aluresult_q;
    assign RTorRd_wb    = rtord_q;
    assign AlignErr     = alignerr_q;
    assign BusErr       = buserr_q;

endmodule
